// File: rtl/chunked_adder.sv
// Multi-cycle adder: A + B + cin, CHUNK bits per clock, with the inter-chunk carry held in a register.
// Valid/ready handshakes on both sides; the result is held in DONE until the consumer takes it.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_reg;
  logic [CNTW-1:0]  cnt;
  logic             msb_a;
  logic             msb_b;

  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] sum_next;

  assign chunk_res = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_reg};

  // New chunk enters at the top; after NCHUNK steps the first chunk has reached bit 0.
  assign sum_next = (sum_sh >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Result registers only change on the final chunk, so they hold through DONE and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      msb_a     <= 1'b0;
      msb_b     <= 1'b0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= A;
            b_sh      <= B;
            carry_reg <= cin;
            msb_a     <= A[WIDTH-1];
            msb_b     <= B[WIDTH-1];
            cnt       <= '0;
          end
        end
        RUN: begin
          a_sh      <= a_sh >> CHUNK;
          b_sh      <= b_sh >> CHUNK;
          sum_sh    <= sum_next;
          carry_reg <= chunk_res[CHUNK];
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_q   <= sum_next;
            carry_q <= chunk_res[CHUNK];
            ovf_q   <= (msb_a == msb_b) && (sum_next[WIDTH-1] != msb_a);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: four parameter sets instantiated side by side, one selected at a time,
// with a queue of expected results filled on accept and drained on the output handshake.
module tb_chunked_adder;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_drv;
  logic [31:0] b_drv;
  logic        cin_drv;
  logic        in_valid_drv;
  logic        out_ready_drv;
  logic [1:0]  sel;

  logic [31:0] sum_o [4];
  logic        ir_o  [4];
  logic        ov_o  [4];
  logic        c_o   [4];
  logic        ovf_o [4];
  logic        bz_o  [4];

  logic [31:0] obs_sum;
  logic        obs_in_ready, obs_out_valid, obs_carry, obs_ovf, obs_busy;

  int   checks   = 0;
  int   failures = 0;
  int   cur_w    = 16;
  int   cur_c    = 4;
  exp_t sbq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = (g == 0) ? 16 : (g == 3) ? 32 : 8;
    localparam int C = (g == 0) ? 4 : (g == 1) ? 1 : 8;
    logic [W-1:0] s;
    logic ir, ov, cy, ovf, bz;
    chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid_drv && (sel == 2'(g))),
      .in_ready(ir),
      .A(a_drv[W-1:0]),
      .B(b_drv[W-1:0]),
      .cin(cin_drv),
      .out_valid(ov),
      .out_ready(out_ready_drv && (sel == 2'(g))),
      .sum(s),
      .carry(cy),
      .overflow(ovf),
      .busy(bz)
    );
    assign sum_o[g] = 32'(s);
    assign ir_o[g]  = ir;
    assign ov_o[g]  = ov;
    assign c_o[g]   = cy;
    assign ovf_o[g] = ovf;
    assign bz_o[g]  = bz;
  end

  assign obs_sum       = sum_o[sel];
  assign obs_in_ready  = ir_o[sel];
  assign obs_out_valid = ov_o[sel];
  assign obs_carry     = c_o[sel];
  assign obs_ovf       = ovf_o[sel];
  assign obs_busy      = bz_o[sel];

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input int w);
    logic [63:0] mask;
    logic [63:0] full;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    full = (64'(a) & mask) + (64'(b) & mask) + 64'(c);
    e.s  = 32'(full & mask);
    e.c  = full[w];
    e.o  = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic use_cfg(input int k);
    sel   = 2'(k);
    cur_w = (k == 0) ? 16 : (k == 3) ? 32 : 8;
    cur_c = (k == 0) ? 4 : (k == 1) ? 1 : 8;
  endtask

  // Holds in_valid until an edge where in_ready was high, then records the expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c);
    int   waitc = 0;
    logic ready_now;
    a_drv        = a;
    b_drv        = b;
    cin_drv      = c;
    in_valid_drv = 1'b1;
    do begin
      ready_now = obs_in_ready;
      @(posedge clk); #1;
      waitc++;
    end while (!ready_now && waitc < 200);
    in_valid_drv = 1'b0;
    checks++;
    if (ready_now !== 1'b1) begin
      failures++;
      $display("[TB] FAIL accept: in_ready=%b after %0d cycles, expected 1", ready_now, waitc);
    end
    sbq.push_back(model(a, b, c, cur_w));
  endtask

  task automatic recv(input int exp_lat);
    int   lat = 0;
    exp_t e;
    out_ready_drv = 1'b1;
    while (!obs_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("[TB] FAIL latency: got %0d cycles, expected %0d (W=%0d C=%0d)", lat, exp_lat, cur_w, cur_c);
    end
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sbq.pop_front();
    checks++;
    if (obs_sum !== e.s) begin
      failures++;
      $display("[TB] FAIL sum: got %h expected %h (W=%0d C=%0d)", obs_sum, e.s, cur_w, cur_c);
    end
    checks++;
    if (obs_carry !== e.c) begin
      failures++;
      $display("[TB] FAIL carry: got %b expected %b (W=%0d C=%0d)", obs_carry, e.c, cur_w, cur_c);
    end
    checks++;
    if (obs_ovf !== e.o) begin
      failures++;
      $display("[TB] FAIL overflow: got %b expected %b (W=%0d C=%0d)", obs_ovf, e.o, cur_w, cur_c);
    end
    @(posedge clk); #1;
    checks++;
    if (obs_out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL handshake: out_valid=%b after handshake, expected 0", obs_out_valid);
    end
  endtask

  task automatic test_reset();
    use_cfg(0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_drv         = $urandom;
      b_drv         = $urandom;
      cin_drv       = 1'($urandom);
      in_valid_drv  = 1'($urandom);
      out_ready_drv = 1'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if ({obs_in_ready, obs_out_valid, obs_busy, obs_carry, obs_ovf} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got ir/ov/busy/c/ovf=%b expected 10000",
               {obs_in_ready, obs_out_valid, obs_busy, obs_carry, obs_ovf});
    end
    checks++;
    if (obs_sum !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_sum: got %h expected 0", obs_sum);
    end
    in_valid_drv  = 1'b0;
    out_ready_drv = 1'b0;
    rst_n         = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({obs_in_ready, obs_out_valid, obs_busy} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got ir/ov/busy=%b expected 100",
               {obs_in_ready, obs_out_valid, obs_busy});
    end
  endtask

  task automatic test_basic();
    use_cfg(0);
    send(32'h1234, 32'h1111, 1'b0);
    checks++;
    if ({obs_busy, obs_in_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL run_flags: got busy/ir=%b expected 10", {obs_busy, obs_in_ready});
    end
    recv(4);
  endtask

  task automatic test_ripple();
    use_cfg(0);
    send(32'hFFFF, 32'h0000, 1'b1);
    recv(4);
    send(32'h7FFF, 32'h0001, 1'b0);
    recv(4);
  endtask

  task automatic test_backpressure();
    int   lat = 0;
    exp_t e;
    use_cfg(0);
    out_ready_drv = 1'b0;
    send(32'hBEEF, 32'h0101, 1'b1);
    out_ready_drv = 1'b0;
    while (!obs_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("[TB] FAIL bp_latency: got %0d expected 4", lat);
    end
    e = sbq.pop_front();
    a_drv        = 32'hFFFF;
    b_drv        = 32'h0002;
    cin_drv      = 1'b0;
    in_valid_drv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({obs_out_valid, obs_in_ready} !== 2'b10 || obs_sum !== e.s || obs_carry !== e.c) begin
        failures++;
        $display("[TB] FAIL bp_hold cycle %0d: got ov/ir=%b sum=%h c=%b expected 10 sum=%h c=%b",
                 i, {obs_out_valid, obs_in_ready}, obs_sum, obs_carry, e.s, e.c);
      end
      @(posedge clk); #1;
    end
    out_ready_drv = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({obs_out_valid, obs_in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL bp_release: got ov/ir=%b expected 01", {obs_out_valid, obs_in_ready});
    end
    send(32'hFFFF, 32'h0002, 1'b0);
    recv(4);
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    use_cfg(0);
    send(32'hAAAA, 32'h5555, 1'b0);
    sbq.delete(sbq.size() - 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs_in_ready, obs_out_valid, obs_busy, obs_carry, obs_ovf} !== 5'b10000 || obs_sum !== 32'h0) begin
      failures++;
      $display("[TB] FAIL async_reset: got ir/ov/busy/c/ovf=%b sum=%h expected 10000 sum=0",
               {obs_in_ready, obs_out_valid, obs_busy, obs_carry, obs_ovf}, obs_sum);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (obs_out_valid || obs_busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("[TB] FAIL aborted_result: got %0d active cycles after reset, expected 0", seen);
    end
  endtask

  task automatic test_sweep();
    for (int k = 1; k < 4; k++) begin
      use_cfg(k);
      for (int n = 0; n < 200; n++) begin
        send($urandom, $urandom, 1'($urandom));
        recv(cur_w / cur_c);
      end
    end
  endtask

  initial begin
    sel           = 2'd0;
    a_drv         = '0;
    b_drv         = '0;
    cin_drv       = 1'b0;
    in_valid_drv  = 1'b0;
    out_ready_drv = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Parametrised, multi-cycle successor to the team's single-bit half adder.
- Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, keeping the inter-chunk carry in a register.
- Sits in the datapath where a full-width combinational adder would miss timing or cost too much area.
- Uses valid/ready handshakes on the input and output sides, so it drops into the team's streaming pipelines.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands A, B, cin are valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum, carry and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  A + B + cin, modulo 2^WIDTH.
- carry  output  1  unsigned carry-out of bit WIDTH-1.
- overflow  output  1  signed overflow: operand MSBs equal and sum MSB differs.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync deassert by usage):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum=0, carry=0, overflow=0; internal operand/carry registers=0; chunk counter=0.
  - Reset mid-operation aborts the addition; the result is lost and not emitted.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A, B into shift registers and cin into the carry register; counter=0; go to RUN.
  - RUN: in_ready=0. Each cycle, add the low CHUNK bits of A_reg, B_reg and carry_reg, then:
    - write the CHUNK-bit result into the top of the sum shift register (sum shifts right by CHUNK);
    - update carry_reg with that chunk's carry-out;
    - shift A_reg, B_reg right by CHUNK;
    - counter++.
    - When counter reaches WIDTH/CHUNK-1, the final chunk is added that cycle; next state is DONE.
  - DONE: out_valid=1. sum, carry and overflow stay stable until out_valid&&out_ready. On handshake go to IDLE, out_valid=0 next cycle.
- Output timing:
  - sum/carry/overflow are only defined while out_valid=1; they hold their last values afterwards.
  - overflow is computed from the latched operand MSBs (a separate 2-bit capture at accept) and the final sum MSB.
- Latency and throughput:
  - Accept edge to out_valid high = WIDTH/CHUNK cycles.
  - If out_ready is held high, a result occupies the block for WIDTH/CHUNK+1 cycles.
  - Next accept is possible in the cycle after the output handshake.
- Degenerate case: CHUNK==WIDTH gives a 1-cycle RUN, i.e. a registered full adder.
- Handshake rules:
  - in_valid while in_ready=0 is ignored; the source must hold it.
  - The block never drops a result; out_valid stays high indefinitely under out_ready=0 backpressure.
  - out_ready while out_valid=0 has no effect.
- Counter width: clog2(WIDTH/CHUNK), minimum 1 bit.

Test Plan:
- Reset, then idle: rst_n=0 for 3 cycles with random inputs -> in_ready=1, out_valid=0, sum=0, carry=0, busy=0; release -> state unchanged until in_valid.
- Basic add, defaults: A=16'h1234, B=16'h1111, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=16'h2345, carry=0, overflow=0.
- Full carry ripple across chunks: A=16'hFFFF, B=16'h0000, cin=1 -> sum=16'h0000, carry=1, overflow=0. Also A=16'h7FFF, B=16'h0001, cin=0 -> sum=16'h8000, carry=0, overflow=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> sum/carry held stable, in_ready=0 throughout, second in_valid not accepted; out_ready=1 -> one-cycle handshake, IDLE, then the second operand pair is accepted and its result follows 4 cycles later.
- Reset mid-RUN: accept A=16'hAAAA, B=16'h5555; assert rst_n=0 two cycles later -> outputs go to reset values immediately (async) and no out_valid appears afterwards.
- Parameter sweep: (WIDTH,CHUNK) = (8,1), (8,8), (32,8), each with 200 random vectors vs a reference model A+B+cin -> all match, latency = WIDTH/CHUNK each time.
